// File: rtl/ins_fetch_sequencer_if.sv
// ins_fetch_sequencer_if: host control, icache ctrl read port and decoder handshake of the fetch sequencer
interface ins_fetch_sequencer_if #(
  parameter int INS_LEN = 54,
  parameter int ADDR_W  = 10
);
  logic               start;
  logic [ADDR_W-1:0]  start_addr;
  logic               abort;
  logic               busy;
  logic               done;
  logic               err;
  logic               icache_rd_ctrl_en;
  logic [ADDR_W-1:0]  icache_rd_ctrl_addr;
  logic [INS_LEN-1:0] icache_rd_ctrl_data;
  logic               ins_valid;
  logic               ins_ready;
  logic [INS_LEN-1:0] ins_data;
  logic [ADDR_W-1:0]  ins_pc;
  modport master (
    input  start, start_addr, abort, icache_rd_ctrl_data, ins_ready,
    output busy, done, err, icache_rd_ctrl_en, icache_rd_ctrl_addr, ins_valid, ins_data, ins_pc
  );
  modport slave (
    output start, start_addr, abort, icache_rd_ctrl_data, ins_ready,
    input  busy, done, err, icache_rd_ctrl_en, icache_rd_ctrl_addr, ins_valid, ins_data, ins_pc
  );
endinterface

// File: rtl/ins_fetch_sequencer.sv
// ins_fetch_sequencer: walks a PC through the instruction cache and hands each word to the decoder
module ins_fetch_sequencer #(
  parameter int              INS_LEN  = 54,
  parameter int              ADDR_W   = 10,
  parameter int              OPC_W    = 4,
  parameter logic [OPC_W-1:0] HALT_OPC = 4'hF
) (
  input logic clk,
  input logic rst,
  ins_fetch_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d, ins_pc_q, ins_pc_d;
  logic [INS_LEN-1:0] ins_data_q, ins_data_d;
  logic [ADDR_W:0]    cnt_q, cnt_d;
  logic               valid_q, valid_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic               slot_free, en, halt;
  assign slot_free = !valid_q || bus.ins_ready;
  assign en        = state_q == RUN && slot_free;
  assign halt      = bus.icache_rd_ctrl_data[INS_LEN-1 -: OPC_W] == HALT_OPC;
  assign bus.icache_rd_ctrl_en   = en;
  assign bus.icache_rd_ctrl_addr = pc_q;
  assign bus.ins_valid = valid_q;
  assign bus.ins_data  = ins_data_q;
  assign bus.ins_pc    = ins_pc_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ins_pc_d   = ins_pc_q;
    ins_data_d = ins_data_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    err_d      = err_q;
    done_d     = 1'b0;
    if (bus.abort) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end else if (state_q == IDLE && bus.start) begin
      state_d = RUN;
      pc_d    = bus.start_addr;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else if (en && halt) begin
      state_d = DRAIN;
      valid_d = 1'b0;
    end else if (en) begin
      ins_data_d = bus.icache_rd_ctrl_data;
      ins_pc_d   = pc_q;
      valid_d    = 1'b1;
      pc_d       = pc_q + 1'b1;
      cnt_d      = cnt_q + 1'b1;
      // MSB of the counter sets exactly on the 2^ADDR_W-th forwarded word
      if (cnt_d[ADDR_W]) begin
        state_d = DRAIN;
        err_d   = 1'b1;
      end
    end else if (state_q == DRAIN && slot_free) begin
      state_d = IDLE;
      valid_d = 1'b0;
      done_d  = 1'b1;
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      ins_pc_q   <= '0;
      ins_data_q <= '0;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ins_pc_q   <= ins_pc_d;
      ins_data_q <= ins_data_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end
endmodule
